// File: rtl/vec_seq_pkg.sv
// Shared types and default constants for the vector-multiplier job sequencer.
package vec_seq_pkg;
  typedef enum logic [2:0] {
    S_IDLE,
    S_WSEL,
    S_WLOAD,
    S_STREAM,
    S_DRAIN,
    S_FIN
  } state_e;

  localparam int SRAM_RD_LAT_DEF = 1;
  localparam int PIPE_LAT_DEF    = 31;
  localparam int CNT_W           = 16;
endpackage

// File: rtl/vec_seq_delay_line.sv
// 1-bit valid delay line with async clear; `empty` means nothing is queued
// behind the output stage, so the entry currently at `dout` is the last one.
module vec_seq_delay_line #(
  parameter int DEPTH = 32
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout,
  output logic empty
);
  logic [DEPTH-1:0] sr_q;
  logic [DEPTH-1:0] sr_d;

  generate
    if (DEPTH == 1) begin : g_single
      always_comb begin
        sr_d  = din;
        empty = 1'b1;
      end
    end else begin : g_multi
      always_comb begin
        sr_d  = {sr_q[DEPTH-2:0], din};
        empty = ~|sr_q[DEPTH-2:0];
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sr_q <= '0;
    else        sr_q <= sr_d;
  end

  assign dout = sr_q[DEPTH-1];
endmodule

// File: rtl/vec_mul_sequencer.sv
// Job controller for the 16x16 vector multiplier: weight select/load, UB streaming,
// result write-back. Optional cycle counter enabled by VEC_SEQ_PERF_CNT_EN.
module vec_mul_sequencer
  import vec_seq_pkg::*;
#(
  parameter int ADDRESSSIZE      = 10,
  parameter int ADDRESSSIZE_fifo = 2,
  parameter int LEN_BW           = 10,
  parameter int SRAM_RD_LAT      = SRAM_RD_LAT_DEF,
  parameter int PIPE_LAT         = PIPE_LAT_DEF
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        start,
  input  logic                        skip_wload,
  input  logic [ADDRESSSIZE_fifo-1:0] tile,
  input  logic [ADDRESSSIZE-1:0]      ub_base,
  input  logic [ADDRESSSIZE-1:0]      res_base,
  input  logic [LEN_BW-1:0]           vec_len,
  output logic                        busy,
  output logic [ADDRESSSIZE_fifo-1:0] fifo_address,
  output logic                        weight_reload,
  output logic [ADDRESSSIZE-1:0]      ub_address,
  output logic                        res_we,
  output logic [ADDRESSSIZE-1:0]      res_address,
  output logic                        done,
  output logic [CNT_W-1:0]            cycle_count
);
  // Reset asserts immediately, releases two edges after rstn rises.
  logic [1:0] rst_sync_q;
  logic [1:0] rst_sync_d;
  logic       rst_n;

  always_comb rst_sync_d = {rst_sync_q[0], 1'b1};

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) rst_sync_q <= 2'b00;
    else       rst_sync_q <= rst_sync_d;
  end

  assign rst_n = rst_sync_q[1];

  state_e                      state_q, state_d;
  logic [ADDRESSSIZE_fifo-1:0] fifo_addr_q, fifo_addr_d;
  logic [ADDRESSSIZE-1:0]      ub_base_q, ub_base_d;
  logic [ADDRESSSIZE-1:0]      ub_addr_q, ub_addr_d;
  logic [ADDRESSSIZE-1:0]      res_addr_q, res_addr_d;
  logic [LEN_BW-1:0]           len_q, len_d;
  logic [LEN_BW-1:0]           cnt_q, cnt_d;
  logic [7:0]                  wait_q, wait_d;
  logic                        issue;
  logic                        start_acc;
  logic                        dl_out;
  logic                        dl_empty;

  assign start_acc = (state_q == S_IDLE) && start;

  always_comb begin
    state_d     = state_q;
    fifo_addr_d = fifo_addr_q;
    ub_base_d   = ub_base_q;
    ub_addr_d   = ub_addr_q;
    res_addr_d  = res_addr_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    wait_d      = wait_q;
    issue       = 1'b0;

    if (dl_out) res_addr_d = res_addr_q + 1'b1;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          ub_base_d  = ub_base;
          len_d      = vec_len;
          cnt_d      = '0;
          wait_d     = '0;
          res_addr_d = res_base;
          if (skip_wload) begin
            state_d = S_STREAM;
            if (vec_len != '0) ub_addr_d = ub_base;
          end else begin
            state_d     = S_WSEL;
            fifo_addr_d = tile;
          end
        end
      end
      S_WSEL: begin
        if (int'(wait_q) + 1 >= SRAM_RD_LAT) state_d = S_WLOAD;
        else                                 wait_d  = wait_q + 1'b1;
      end
      S_WLOAD: begin
        state_d = S_STREAM;
        if (len_q != '0) ub_addr_d = ub_base_q;
      end
      S_STREAM: begin
        // ub_address already shows the vector being issued; advance only if another follows.
        if (cnt_q == len_q) begin
          state_d = S_DRAIN;
        end else begin
          issue = 1'b1;
          cnt_d = cnt_q + 1'b1;
          if (cnt_d == len_q) state_d   = S_DRAIN;
          else                ub_addr_d = ub_addr_q + 1'b1;
        end
      end
      S_DRAIN: begin
        if (dl_empty) state_d = S_FIN;
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      fifo_addr_q <= '0;
      ub_base_q   <= '0;
      ub_addr_q   <= '0;
      res_addr_q  <= '0;
      len_q       <= '0;
      cnt_q       <= '0;
      wait_q      <= '0;
    end else begin
      state_q     <= state_d;
      fifo_addr_q <= fifo_addr_d;
      ub_base_q   <= ub_base_d;
      ub_addr_q   <= ub_addr_d;
      res_addr_q  <= res_addr_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      wait_q      <= wait_d;
    end
  end

  vec_seq_delay_line #(
    .DEPTH(SRAM_RD_LAT + PIPE_LAT)
  ) u_delay (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (issue),
    .dout (dl_out),
    .empty(dl_empty)
  );

  assign busy          = (state_q != S_IDLE);
  assign weight_reload = (state_q == S_WLOAD);
  assign done          = (state_q == S_FIN);
  assign fifo_address  = fifo_addr_q;
  assign ub_address    = ub_addr_q;
  assign res_we        = dl_out;
  assign res_address   = res_addr_q;

`ifdef VEC_SEQ_PERF_CNT_EN
  logic [CNT_W-1:0] perf_q, perf_d;

  always_comb begin
    perf_d = perf_q;
    if (start_acc)                 perf_d = '0;
    else if (busy && perf_q != '1) perf_d = perf_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) perf_q <= '0;
    else        perf_q <= perf_d;
  end

  assign cycle_count = perf_q;
`else
  logic unused_start_acc;
  assign unused_start_acc = start_acc;
  assign cycle_count      = '0;
`endif
endmodule

// File: tb/tb_vec_mul_sequencer.sv
// Self-checking bench for vec_mul_sequencer: directed and random jobs against a
// per-cycle event model derived from the job timing rules.
module tb_vec_mul_sequencer;
  localparam int D = 32;

  logic        clk = 1'b0;
  logic        rstn = 1'b1;
  logic        start = 1'b0;
  logic        skip_wload = 1'b0;
  logic [1:0]  tile = '0;
  logic [9:0]  ub_base = '0;
  logic [9:0]  res_base = '0;
  logic [9:0]  vec_len = '0;
  logic        busy;
  logic [1:0]  fifo_address;
  logic        weight_reload;
  logic [9:0]  ub_address;
  logic        res_we;
  logic [9:0]  res_address;
  logic        done;
  logic [15:0] cycle_count;

  int vectors = 0;
  int miscompares = 0;
  int job_no = 0;
  logic [1:0] m_tile = '0;
  logic [9:0] m_ub = '0;

  vec_mul_sequencer dut (
    .clk          (clk),
    .rstn         (rstn),
    .start        (start),
    .skip_wload   (skip_wload),
    .tile         (tile),
    .ub_base      (ub_base),
    .res_base     (res_base),
    .vec_len      (vec_len),
    .busy         (busy),
    .fifo_address (fifo_address),
    .weight_reload(weight_reload),
    .ub_address   (ub_address),
    .res_we       (res_we),
    .res_address  (res_address),
    .done         (done),
    .cycle_count  (cycle_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".busy"}, 32'(busy), 0);
    chk({tag, ".fifo_address"}, 32'(fifo_address), 0);
    chk({tag, ".weight_reload"}, 32'(weight_reload), 0);
    chk({tag, ".ub_address"}, 32'(ub_address), 0);
    chk({tag, ".res_we"}, 32'(res_we), 0);
    chk({tag, ".res_address"}, 32'(res_address), 0);
    chk({tag, ".done"}, 32'(done), 0);
    chk({tag, ".cycle_count"}, 32'(cycle_count), 0);
  endtask

  // Model: stream starts at t0 (1 when skipping the load, else 3); issue i at t0+i,
  // its write at t0+D+i, done right after the last write; held outputs keep old values.
  task automatic run_job(input logic [1:0] t, input logic [9:0] ub, input logic [9:0] rb,
                         input logic [9:0] n, input logic sk, input int ghost_c);
    int t0, exp_done, budget, done_seen, done_c;
    logic [9:0] exp_ub;
    logic [9:0] exp_ra;
    logic       we_exp;
    t0        = sk ? 1 : 3;
    exp_done  = (n != 0) ? t0 + D + int'(n) : -1;
    budget    = (n != 0) ? exp_done + 1 : 60;
    exp_ub    = m_ub;
    done_seen = 0;
    done_c    = 0;
    job_no++;
    $display("job %0d: tile=%0d ub_base=0x%03h res_base=0x%03h len=%0d skip=%0b ghost=%0d",
             job_no, t, ub, rb, n, sk, ghost_c);
    start = 1'b1; skip_wload = sk; tile = t; ub_base = ub; res_base = rb; vec_len = n;
    for (int c = 1; c <= budget; c++) begin
      tick();
      if (!sk) m_tile = t;
      if (n != 0 && c >= t0 && c < t0 + int'(n)) exp_ub = ub + 10'(c - t0);
      we_exp = (n != 0) && (c >= t0 + D) && (c < t0 + D + int'(n));
      chk("fifo_address", 32'(fifo_address), 32'(m_tile));
      chk("ub_address", 32'(ub_address), 32'(exp_ub));
      chk("weight_reload", 32'(weight_reload), 32'(!sk && c == 2));
      chk("res_we", 32'(res_we), 32'(we_exp));
      if (we_exp) begin
        exp_ra = rb + 10'(c - t0 - D);
        chk("res_address", 32'(res_address), 32'(exp_ra));
      end
      if (n != 0) begin
        chk("done", 32'(done), 32'(c == exp_done));
        chk("busy", 32'(busy), 32'(c <= exp_done));
`ifdef VEC_SEQ_PERF_CNT_EN
        if (c == exp_done + 1) chk("cycle_count", 32'(cycle_count), 32'(exp_done));
`endif
      end else begin
        if (done_seen != 0 && c > done_c) chk("busy_after_done", 32'(busy), 0);
        if (done === 1'b1) begin
          done_seen++;
          done_c = c;
        end
      end
`ifndef VEC_SEQ_PERF_CNT_EN
      chk("cycle_count", 32'(cycle_count), 0);
`endif
      // Scramble job inputs so only latched values can be in use.
      start = (c == ghost_c); tile = 2'($urandom); ub_base = 10'($urandom);
      res_base = 10'($urandom); vec_len = 10'($urandom_range(1, 50)); skip_wload = 1'($urandom);
      if (n == 0 && done_seen != 0 && c >= done_c + 2) break;
    end
    start = 1'b0;
    if (n == 0) begin
      chk("done_pulses", 32'(done_seen), 1);
`ifdef VEC_SEQ_PERF_CNT_EN
      chk("cycle_count", 32'(cycle_count), 32'(done_c));
`endif
    end
    m_ub = exp_ub;
  endtask

  initial begin
    #1 rstn = 1'b0;
    tick(); tick();
    chk_all_zero("reset");
    rstn = 1'b1;
    tick(); tick(); tick();

    run_job(2'd2, 10'h010, 10'h100, 10'd4, 1'b0, -1);
    run_job(2'd2, 10'h010, 10'h100, 10'd4, 1'b1, -1);
    run_job(2'd1, 10'h3FE, 10'h3FF, 10'd3, 1'b0, -1);
    run_job(2'd3, 10'h055, 10'h066, 10'd0, 1'b0, -1);
    run_job(2'd0, 10'h055, 10'h066, 10'd0, 1'b1, -1);
    run_job(2'd2, 10'h020, 10'h200, 10'd6, 1'b0, 5);

    // Abort a 4-vector job at cycle 20, before any of its writes are due.
    $display("job %0d: reset abort at cycle 20", job_no + 1);
    job_no++;
    start = 1'b1; skip_wload = 1'b0; tile = 2'd1; ub_base = 10'h0A0; res_base = 10'h0B0; vec_len = 10'd4;
    for (int c = 1; c <= 20; c++) begin
      tick();
      start = 1'b0;
    end
    rstn = 1'b0;
    #1;
    chk_all_zero("abort");
    tick(); tick();
    rstn = 1'b1;
    for (int c = 0; c < 50; c++) begin
      tick();
      chk("post_abort.res_we", 32'(res_we), 0);
      chk("post_abort.busy", 32'(busy), 0);
    end
    m_tile = '0;
    m_ub   = '0;

    for (int j = 0; j < 10; j++) begin
      logic [9:0] n;
      n = 10'($urandom_range(0, 9));
      run_job(2'($urandom), 10'($urandom), 10'($urandom), n, 1'($urandom),
              (n == 0) ? -1 : int'($urandom_range(1, 20)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
